// File: rtl/xorshift_mix_pkg.sv
// Shared types and helpers for the xorshift mix generator.
// FSM encoding, fold-index helper and default output tap set.
package xorshift_mix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam int SEL_W_DEF = 5;

  localparam logic [4*SEL_W_DEF-1:0] OUT_SEL_DEF = {
    5'd15, 5'd9, 5'd5, 5'd3
  };

  function automatic int fold_idx(
    input int i,
    input int ofs,
    input int fold
  );
    return (i + ofs) % fold;
  endfunction

endpackage

// File: rtl/xorshift_mix_if.sv
// Seed-load and run-request handshake bundle.
// Master offers seeds and run requests; slave is the generator.
interface xorshift_mix_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);

  logic             seed_valid;
  logic             seed_ready;
  logic [WIDTH-1:0] seed_data;
  logic             start;
  logic [CNT_W-1:0] run_len;

  modport master (
    output seed_valid,
    output seed_data,
    output start,
    output run_len,
    input  seed_ready
  );

  modport slave (
    input  seed_valid,
    input  seed_data,
    input  start,
    input  run_len,
    output seed_ready
  );

endinterface

// File: rtl/xorshift_mix_step.sv
// Combinational next-state function of the mix register.
// Low lanes load serial inputs; the rest XOR four fixed taps.
module xorshift_mix_step
  import xorshift_mix_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int N_IN     = 2,
  parameter int TAP_A    = 3,
  parameter int TAP_B    = 30,
  parameter int TAP_C    = 2,
  parameter int FOLD_OFS = 4,
  parameter int FOLD     = 16
) (
  input  logic [WIDTH-1:0] s,
  input  logic [N_IN-1:0]  in_bits,
  output logic [WIDTH-1:0] nxt
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i < N_IN) begin : g_in
      assign nxt[i] = in_bits[i];
    end else begin : g_mix
      localparam int IA = (i + TAP_A) % WIDTH;
      localparam int IB = (i + TAP_B) % WIDTH;
      localparam int IC = (i + TAP_C) % WIDTH;
      localparam int IF = fold_idx(i, FOLD_OFS, FOLD);
      assign nxt[i] = s[IA] ^ s[IB] ^ s[IF] ^ s[IC];
    end
  end

endmodule

// File: rtl/xorshift_mix_gen.sv
// XOR-feedback mix register with seed load, bounded runs, done pulse.
// Optional signature register: define XORSHIFT_MIX_SIGNATURE_EN.
module xorshift_mix_gen
  import xorshift_mix_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int N_IN     = 2,
  parameter int TAP_A    = 3,
  parameter int TAP_B    = 30,
  parameter int TAP_C    = 2,
  parameter int FOLD_OFS = 4,
  parameter int FOLD     = 16,
  parameter int N_OUT    = 4,
  parameter logic [N_OUT*$clog2(WIDTH)-1:0] OUT_SEL = OUT_SEL_DEF,
  parameter int CNT_W    = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             clr,
  xorshift_mix_if.slave    ctl,
  input  logic [N_IN-1:0]  in_bits,
  output logic [N_OUT-1:0] out_bits,
  output logic [WIDTH-1:0] state_q,
  output logic             busy,
  output logic             done
`ifdef XORSHIFT_MIX_SIGNATURE_EN
  ,
  output logic [WIDTH-1:0] sig_q
`endif
);

  localparam int SEL_W = $clog2(WIDTH);

  fsm_t             st;
  fsm_t             st_nxt;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             step;

  xorshift_mix_step #(
    .WIDTH   (WIDTH),
    .N_IN    (N_IN),
    .TAP_A   (TAP_A),
    .TAP_B   (TAP_B),
    .TAP_C   (TAP_C),
    .FOLD_OFS(FOLD_OFS),
    .FOLD    (FOLD)
  ) u_step (
    .s      (state),
    .in_bits(in_bits),
    .nxt    (nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      state <= RESET_VAL;
      cnt   <= '0;
    end else begin
      st    <= st_nxt;
      state <= state_d;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    st_nxt  = st;
    state_d = state;
    cnt_nxt = cnt;
    step    = 1'b0;
    unique case (st)
      IDLE: begin
        if (ctl.seed_valid) begin
          state_d = ctl.seed_data;
        end
        if (ctl.start) begin
          if (ctl.run_len != '0) begin
            cnt_nxt = ctl.run_len;
            st_nxt  = RUN;
          end else begin
            st_nxt  = DONE;
          end
        end
      end
      RUN: begin
        if (cen) begin
          step    = 1'b1;
          state_d = nxt;
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            st_nxt = DONE;
          end
        end
      end
      DONE: begin
        st_nxt = IDLE;
      end
      default: begin
        st_nxt = IDLE;
      end
    endcase
    // clear wins over everything, including a step in flight
    if (clr) begin
      st_nxt  = IDLE;
      state_d = RESET_VAL;
      cnt_nxt = '0;
      step    = 1'b0;
    end
  end

  assign ctl.seed_ready = (st == IDLE);
  assign busy           = (st == RUN);
  assign done           = (st == DONE);
  assign state_q        = state;

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    localparam int IDX = int'(OUT_SEL[k*SEL_W +: SEL_W]);
    assign out_bits[k] = state[IDX];
  end

`ifdef XORSHIFT_MIX_SIGNATURE_EN
  logic [WIDTH-1:0] sig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (step) begin
      sig <= {sig[WIDTH-2:0], sig[WIDTH-1]} ^ nxt;
    end
  end

  assign sig_q = sig;
`endif

endmodule

// File: tb/tb_xorshift_mix_gen.sv
// Directed self-checking bench for xorshift_mix_gen.
// Default parameters; sig_q checked when XORSHIFT_MIX_SIGNATURE_EN is set.
module tb_xorshift_mix_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen;
  logic        clr;
  logic [1:0]  in_bits;
  logic [3:0]  out_bits;
  logic [31:0] state_q;
  logic        busy;
  logic        done;
`ifdef XORSHIFT_MIX_SIGNATURE_EN
  logic [31:0] sig_q;
`endif

  int checks   = 0;
  int failures = 0;

  xorshift_mix_if #(.WIDTH(32), .CNT_W(16)) ctl ();

  xorshift_mix_gen dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .clr     (clr),
    .ctl     (ctl),
    .in_bits (in_bits),
    .out_bits(out_bits),
    .state_q (state_q),
    .busy    (busy),
    .done    (done)
`ifdef XORSHIFT_MIX_SIGNATURE_EN
    ,
    .sig_q   (sig_q)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_step(
    input logic [31:0] s,
    input logic [1:0]  ib
  );
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      if (i < 2) r[i] = ib[i];
      else r[i] = s[(i + 3) % 32] ^ s[(i + 30) % 32]
                ^ s[(i + 4) % 16] ^ s[(i + 2) % 32];
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_out(input logic [31:0] s);
    return {s[15], s[9], s[5], s[3]};
  endfunction

  function automatic logic [31:0] rotl1(input logic [31:0] v);
    return {v[30:0], v[31]};
  endfunction

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] m;
  logic [31:0] sigm;
  int          n;
  int          dones;

  initial begin
    rst_n          = 1'b0;
    cen            = 1'b0;
    clr            = 1'b0;
    in_bits        = 2'b00;
    ctl.seed_valid = 1'b0;
    ctl.seed_data  = '0;
    ctl.start      = 1'b0;
    ctl.run_len    = '0;
    sigm           = '0;
    #12;
    check("rst_state", 64'(state_q), 64'h0);
    check("rst_out", 64'(out_bits), 64'h0);
    check("rst_ready", 64'(ctl.seed_ready), 64'h1);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
`ifdef XORSHIFT_MIX_SIGNATURE_EN
    check("rst_sig", 64'(sig_q), 64'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // seed 8 together with start, one step
    ctl.seed_valid = 1'b1;
    ctl.seed_data  = 32'h0000_0008;
    ctl.start      = 1'b1;
    ctl.run_len    = 16'd1;
    cen            = 1'b1;
    in_bits        = 2'b00;
    tick();
    check("s1_seeded", 64'(state_q), 64'h8);
    check("s1_busy", 64'(busy), 64'h1);
    check("s1_ready", 64'(ctl.seed_ready), 64'h0);
    ctl.seed_valid = 1'b0;
    ctl.start      = 1'b0;
    tick();
    check("s1_state", 64'(state_q), 64'h8000_8020);
    check("s1_out", 64'(out_bits), 64'b1010);
    check("s1_done", 64'(done), 64'h1);
    check("s1_busy_off", 64'(busy), 64'h0);
    sigm = 32'h8000_8020;
`ifdef XORSHIFT_MIX_SIGNATURE_EN
    check("s1_sig", 64'(sig_q), 64'h8000_8020);
`endif
    tick();
    check("s1_done_pulse", 64'(done), 64'h0);
    check("s1_ready_back", 64'(ctl.seed_ready), 64'h1);

    // five steps with cen toggling
    ctl.seed_valid = 1'b1;
    ctl.seed_data  = 32'h0000_0008;
    ctl.start      = 1'b1;
    ctl.run_len    = 16'd5;
    in_bits        = 2'b01;
    tick();
    ctl.seed_valid = 1'b0;
    ctl.start      = 1'b0;
    m     = 32'h0000_0008;
    n     = 0;
    dones = 0;
    while (busy && n < 40) begin
      n++;
      cen = n[0];
      if (cen) begin
        m    = ref_step(m, in_bits);
        sigm = rotl1(sigm) ^ m;
      end
      tick();
      if (done) dones++;
    end
    check("r5_busy_cycles", 64'(n), 64'd9);
    check("r5_done_seen", 64'(dones), 64'd1);
    check("r5_state", 64'(state_q), 64'(m));
    check("r5_out", 64'(out_bits), 64'(ref_out(m)));
`ifdef XORSHIFT_MIX_SIGNATURE_EN
    check("r5_sig", 64'(sig_q), 64'(sigm));
`endif
    cen = 1'b1;
    tick();
    check("r5_done_pulse", 64'(done), 64'h0);
    check("r5_state_hold", 64'(state_q), 64'(m));

    // clear in the middle of a run
    ctl.seed_valid = 1'b1;
    ctl.seed_data  = 32'h0000_0008;
    ctl.start      = 1'b1;
    ctl.run_len    = 16'd5;
    tick();
    ctl.seed_valid = 1'b0;
    ctl.start      = 1'b0;
    tick();
    tick();
    check("clr_pre_busy", 64'(busy), 64'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_state", 64'(state_q), 64'h0);
    check("clr_busy", 64'(busy), 64'h0);
    check("clr_ready", 64'(ctl.seed_ready), 64'h1);
`ifdef XORSHIFT_MIX_SIGNATURE_EN
    check("clr_sig", 64'(sig_q), 64'h0);
`endif
    sigm  = '0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) dones++;
    end
    check("clr_no_done", 64'(dones), 64'd0);

    // zero-length run
    ctl.seed_valid = 1'b1;
    ctl.seed_data  = 32'h1234_5678;
    tick();
    ctl.seed_valid = 1'b0;
    check("z_seed", 64'(state_q), 64'h1234_5678);
    ctl.start   = 1'b1;
    ctl.run_len = 16'd0;
    tick();
    ctl.start = 1'b0;
    check("z_done", 64'(done), 64'h1);
    check("z_busy", 64'(busy), 64'h0);
    check("z_state", 64'(state_q), 64'h1234_5678);
    tick();
    check("z_done_pulse", 64'(done), 64'h0);

    // seed offered during a run is ignored
    m           = 32'h1234_5678;
    in_bits     = 2'b10;
    ctl.start   = 1'b1;
    ctl.run_len = 16'd2;
    tick();
    ctl.seed_valid = 1'b1;
    ctl.seed_data  = 32'hFFFF_FFFF;
    check("sr_ready", 64'(ctl.seed_ready), 64'h0);
    m    = ref_step(m, in_bits);
    sigm = rotl1(sigm) ^ m;
    tick();
    check("sr_step1", 64'(state_q), 64'(m));
    m    = ref_step(m, in_bits);
    sigm = rotl1(sigm) ^ m;
    tick();
    ctl.seed_valid = 1'b0;
    ctl.start      = 1'b0;
    check("sr_step2", 64'(state_q), 64'(m));
    check("sr_done", 64'(done), 64'h1);
`ifdef XORSHIFT_MIX_SIGNATURE_EN
    check("sr_sig", 64'(sig_q), 64'(sigm));
`endif
    tick();
    check("sr_idle", 64'(ctl.seed_ready), 64'h1);
    check("sr_hold", 64'(state_q), 64'(m));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
